// File: rtl/keypoint_scan_if.sv
// Bundle of the pixel stream, 3x3 window, filter result and keypoint stream
// seen by the raster-scan sequencer. master = environment side, slave = sequencer.
interface keypoint_scan_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          start;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [23:0]   win_top;
    logic [23:0]   win_mid;
    logic [23:0]   win_btm;
    logic          win_valid;
    logic          valid_keypoint;
    logic [XW-1:0] kp_x;
    logic [YW-1:0] kp_y;
    logic          kp_valid;
    logic          kp_ready;
    logic          busy;
    logic          done;
    logic [15:0]   kp_count;

    modport master (
        output start, pix_in, pix_valid, valid_keypoint, kp_ready,
        input  pix_ready, win_top, win_mid, win_btm, win_valid,
               kp_x, kp_y, kp_valid, busy, done, kp_count
    );

    modport slave (
        input  start, pix_in, pix_valid, valid_keypoint, kp_ready,
        output pix_ready, win_top, win_mid, win_btm, win_valid,
               kp_x, kp_y, kp_valid, busy, done, kp_count
    );
endinterface

// File: rtl/keypoint_scan_ctrl.sv
// Raster-scan sequencer for a FAST-style keypoint filter: two line buffers feed
// a 3x3 window, filter hits are queued as (x,y) in a small FWFT FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; no pixels accepted
// RUN   | accepting pixels, building windows, pushing keypoints
// DRAIN | last pixel taken; waiting for final window and empty FIFO
module keypoint_scan_ctrl #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int XW         = 10,
    parameter int YW         = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    keypoint_scan_if.slave bus
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic [XW-1:0]    col;
    logic [YW-1:0]    row;
    logic [23:0]      win_top, win_mid, win_btm;
    logic             win_valid;
    logic [XW-1:0]    win_cx;
    logic [YW-1:0]    win_cy;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [OW-1:0]    occ;
    logic [15:0]      kp_count;
    logic             done;
    logic             pix_ready, busy;
    logic [7:0]       linebuf0 [IMG_W];
    logic [7:0]       linebuf1 [IMG_W];
    logic [XW+YW-1:0] fifo_mem [FIFO_DEPTH];
    logic [XW+YW-1:0] head;
    logic [AW-1:0]    lb_idx;
    logic             accept, last_pix, push, pop, kp_valid;
    logic             frame_start, drain_done;

    assign lb_idx      = col[AW-1:0];
    assign accept      = bus.pix_valid && pix_ready;
    assign last_pix    = accept && (col == COL_LAST) && (row == ROW_LAST);
    assign kp_valid    = (occ != '0);
    assign push        = win_valid && bus.valid_keypoint;
    assign pop         = kp_valid && bus.kp_ready;
    assign frame_start = (state == S_IDLE) && bus.start;
    assign drain_done  = (state == S_DRAIN) && !win_valid && (occ == '0);
    assign head        = fifo_mem[rd_ptr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last_pix) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; backpressure counts the window that may still push next edge.
    always_comb begin
        busy      = 1'b0;
        pix_ready = 1'b0;
        case (state)
            S_RUN: begin
                busy      = 1'b1;
                pix_ready = (occ + OW'(win_valid)) < OW'(FIFO_DEPTH);
            end
            S_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end
    end

    // Window shift; only fully interior windows (no row wrap) are flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_top   <= '0;
            win_mid   <= '0;
            win_btm   <= '0;
            win_valid <= 1'b0;
            win_cx    <= '0;
            win_cy    <= '0;
        end else begin
            win_valid <= accept && (col >= XW'(2)) && (row >= YW'(2));
            if (accept) begin
                win_top <= {linebuf1[lb_idx], win_top[23:8]};
                win_mid <= {linebuf0[lb_idx], win_mid[23:8]};
                win_btm <= {bus.pix_in,       win_btm[23:8]};
                win_cx  <= col - XW'(1);
                win_cy  <= row - YW'(1);
            end
        end
    end

    // Line buffers; stale contents are never used because row gating masks them.
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1[lb_idx] <= linebuf0[lb_idx];
            linebuf0[lb_idx] <= bus.pix_in;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {win_cx, win_cy};
    end

    // FIFO pointers, occupancy, keypoint counter and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            kp_count <= '0;
            done     <= 1'b0;
        end else begin
            done <= drain_done;
            if (frame_start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
                kp_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      occ <= occ + OW'(1);
                else if (pop && !push) occ <= occ - OW'(1);
                if (push && (kp_count != 16'hFFFF)) kp_count <= kp_count + 16'd1;
            end
        end
    end

    assign bus.pix_ready = pix_ready;
    assign bus.win_top   = win_top;
    assign bus.win_mid   = win_mid;
    assign bus.win_btm   = win_btm;
    assign bus.win_valid = win_valid;
    assign bus.kp_valid  = kp_valid;
    assign bus.kp_x      = kp_valid ? head[XW+YW-1:YW] : '0;
    assign bus.kp_y      = kp_valid ? head[YW-1:0]     : '0;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.kp_count  = kp_count;
endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Directed bench for keypoint_scan_ctrl on an 8x6 image with a behavioural
// FAST filter and a coordinate scoreboard.
module tb_keypoint_scan_ctrl;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int FD    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypoint_scan_if #(.XW(XW), .YW(YW)) kif();

    keypoint_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(kif)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  img [IMG_H][IMG_W];
    logic [31:0] sb [$];

    int pop_cnt, done_cnt, wv_cnt, last_x, last_y;
    int mcol, mrow, prev_c, prev_r;
    bit prev_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ring[8*i+:8], i=0..7: NW, N, NE, E, SE, S, SW, W
    function automatic logic fast_kp(input logic [7:0] p, input logic [63:0] ring);
        logic [7:0] bri, drk;
        logic all_b, all_d;
        for (int i = 0; i < 8; i++) begin
            bri[i] = int'(ring[8*i +: 8]) > int'(p) + 7;
            drk[i] = int'(ring[8*i +: 8]) + 7 < int'(p);
        end
        for (int s = 0; s < 8; s++) begin
            all_b = 1'b1;
            all_d = 1'b1;
            for (int k = 0; k < 4; k++) begin
                all_b = all_b & bri[(s + k) % 8];
                all_d = all_d & drk[(s + k) % 8];
            end
            if (all_b || all_d) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic model_kp(input int x, input int y);
        logic [63:0] ring;
        ring = {img[y][x-1], img[y+1][x-1], img[y+1][x], img[y+1][x+1],
                img[y][x+1], img[y-1][x+1], img[y-1][x], img[y-1][x-1]};
        return fast_kp(img[y][x], ring);
    endfunction

    always_comb begin
        kif.valid_keypoint = fast_kp(kif.win_mid[15:8],
            {kif.win_mid[7:0], kif.win_btm[7:0], kif.win_btm[15:8], kif.win_btm[23:16],
             kif.win_mid[23:16], kif.win_top[23:16], kif.win_top[15:8], kif.win_top[7:0]});
    end

    // Monitor: window/valid checks and scoreboard pops, sampled on the falling edge.
    initial begin : monitor
        logic exp_wv;
        logic [31:0] item;
        prev_acc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_acc = 0;
            end else begin
                if (kif.start && !kif.busy) begin
                    mcol = 0; mrow = 0; pop_cnt = 0; done_cnt = 0; wv_cnt = 0;
                    prev_acc = 0;
                end
                exp_wv = prev_acc && prev_c >= 2 && prev_r >= 2;
                check("win_valid", {31'd0, kif.win_valid}, {31'd0, exp_wv});
                if (kif.win_valid) wv_cnt++;
                if (exp_wv) begin
                    check("win_top", {8'd0, kif.win_top},
                          {8'd0, img[prev_r-2][prev_c], img[prev_r-2][prev_c-1], img[prev_r-2][prev_c-2]});
                    check("win_mid", {8'd0, kif.win_mid},
                          {8'd0, img[prev_r-1][prev_c], img[prev_r-1][prev_c-1], img[prev_r-1][prev_c-2]});
                    check("win_btm", {8'd0, kif.win_btm},
                          {8'd0, img[prev_r][prev_c], img[prev_r][prev_c-1], img[prev_r][prev_c-2]});
                end
                prev_acc = kif.pix_valid && kif.pix_ready;
                if (prev_acc) begin
                    prev_c = mcol;
                    prev_r = mrow;
                    if (mcol == IMG_W - 1) begin mcol = 0; mrow++; end
                    else mcol++;
                end
                if (kif.kp_valid && kif.kp_ready) begin
                    check("kp_expected", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        item = sb.pop_front();
                        check("kp_xy", {16'(kif.kp_x), 16'(kif.kp_y)}, item);
                    end
                    last_x = int'(kif.kp_x);
                    last_y = int'(kif.kp_y);
                    pop_cnt++;
                end
                if (kif.done) done_cnt++;
            end
        end
    end

    task automatic fill(input logic [7:0] bg);
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                img[y][x] = bg;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        kif.start = 1'b1;
        @(posedge clk); #1;
        kif.start = 1'b0;
    endtask

    // Streams pixels in raster order; releases kp_ready after a long stall if asked.
    task automatic send_frame(input int stop_after, input int release_after, output bit stalled);
        int c, r, stall, n_acc;
        bit rel;
        logic [XW-1:0] hx;
        logic [YW-1:0] hy;
        c = 0; r = 0; stall = 0; n_acc = 0; stalled = 0; rel = 0; hx = '0; hy = '0;
        while (n_acc < stop_after && stall < 300) begin
            kif.pix_valid = 1'b1;
            kif.pix_in    = img[r][c];
            @(negedge clk);
            if (kif.pix_ready) begin
                if (c >= 2 && r >= 2 && model_kp(c - 1, r - 1))
                    sb.push_back({16'(c - 1), 16'(r - 1)});
                n_acc++;
                stall = 0;
                if (c == IMG_W - 1) begin c = 0; r++; end
                else c++;
            end else begin
                stall++;
                if (stall == 1) begin hx = kif.kp_x; hy = kif.kp_y; end
                if (release_after > 0 && stall == release_after && !stalled) begin
                    stalled = 1;
                    rel = 1;
                    check("bp_kp_count", {16'd0, kif.kp_count}, 32'd4);
                    check("bp_kp_valid", {31'd0, kif.kp_valid}, 32'd1);
                    check("bp_hold_xy", {16'(kif.kp_x), 16'(kif.kp_y)}, {16'(hx), 16'(hy)});
                end
            end
            @(posedge clk); #1;
            if (rel) kif.kp_ready = 1'b1;
        end
        kif.pix_valid = 1'b0;
        check("accepts", n_acc, stop_after);
    endtask

    task automatic finish_frame(input int exp_kp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (kif.done) begin
                seen = 1;
                check("busy_at_done", {31'd0, kif.busy}, 32'd0);
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 32'd1);
        check("kp_count", {16'd0, kif.kp_count}, exp_kp);
        check("pops", pop_cnt, exp_kp);
        check("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        bit stalled;
        kif.start = 0; kif.pix_in = 0; kif.pix_valid = 0; kif.kp_ready = 0;
        #2;
        check("rst_pix_ready", {31'd0, kif.pix_ready}, 32'd0);
        check("rst_kp_valid",  {31'd0, kif.kp_valid}, 32'd0);
        check("rst_busy",      {31'd0, kif.busy}, 32'd0);
        check("rst_done",      {31'd0, kif.done}, 32'd0);
        check("rst_kp_count",  {16'd0, kif.kp_count}, 32'd0);
        check("rst_win_mid",   {8'd0, kif.win_mid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // flat frame
        kif.kp_ready = 1'b1;
        fill(8'd100);
        sb.delete();
        start_frame();
        check("busy_run", {31'd0, kif.busy}, 32'd1);
        send_frame(IMG_W * IMG_H, 0, stalled);
        finish_frame(0);
        check("flat_windows", wv_cnt, 32'd24);

        // single bright pixel
        fill(8'd100);
        img[3][4] = 8'd200;
        start_frame();
        send_frame(IMG_W * IMG_H, 0, stalled);
        finish_frame(1);
        check("single_xy", {16'(last_x), 16'(last_y)}, {16'd4, 16'd3});

        // threshold: 8 above is brighter
        fill(8'd108);
        img[2][3] = 8'd100;
        start_frame();
        send_frame(IMG_W * IMG_H, 0, stalled);
        finish_frame(1);
        check("thr_xy", {16'(last_x), 16'(last_y)}, {16'd3, 16'd2});

        // threshold: 7 above is not brighter
        fill(8'd107);
        img[2][3] = 8'd100;
        start_frame();
        send_frame(IMG_W * IMG_H, 0, stalled);
        finish_frame(0);

        // backpressure
        fill(8'd100);
        img[1][1] = 8'd200; img[1][3] = 8'd200; img[1][5] = 8'd200;
        img[3][2] = 8'd200; img[3][4] = 8'd200; img[3][6] = 8'd200;
        kif.kp_ready = 1'b0;
        start_frame();
        send_frame(IMG_W * IMG_H, 20, stalled);
        check("bp_stalled", {31'd0, stalled}, 32'd1);
        finish_frame(6);
        check("bp_last_xy", {16'(last_x), 16'(last_y)}, {16'd6, 16'd3});

        // border pixels
        kif.kp_ready = 1'b1;
        fill(8'd100);
        img[2][0] = 8'd200;
        img[3][7] = 8'd200;
        start_frame();
        send_frame(IMG_W * IMG_H, 0, stalled);
        finish_frame(0);
        check("edge_windows", wv_cnt, 32'd24);

        // reset mid row 3 with FIFO non-empty
        fill(8'd100);
        img[1][2] = 8'd200;
        img[1][5] = 8'd200;
        kif.kp_ready = 1'b0;
        start_frame();
        send_frame(3 * IMG_W + 4, 0, stalled);
        check("pre_rst_kp_valid", {31'd0, kif.kp_valid}, 32'd1);
        check("pre_rst_kp_count", {16'd0, kif.kp_count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pix_ready", {31'd0, kif.pix_ready}, 32'd0);
        check("mid_rst_kp_valid",  {31'd0, kif.kp_valid}, 32'd0);
        check("mid_rst_kp_xy",     {16'(kif.kp_x), 16'(kif.kp_y)}, 32'd0);
        check("mid_rst_busy",      {31'd0, kif.busy}, 32'd0);
        check("mid_rst_kp_count",  {16'd0, kif.kp_count}, 32'd0);
        check("mid_rst_win_valid", {31'd0, kif.win_valid}, 32'd0);
        check("mid_rst_win_top",   {8'd0, kif.win_top}, 32'd0);
        check("mid_rst_win_btm",   {8'd0, kif.win_btm}, 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_rst", {31'd0, kif.busy}, 32'd0);
        kif.kp_ready = 1'b1;
        start_frame();
        send_frame(IMG_W * IMG_H, 0, stalled);
        finish_frame(2);
        check("rerun_last_xy", {16'(last_x), 16'(last_y)}, {16'd5, 16'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
